// File: rtl/config_chain_sequencer.sv
// rtl/config_chain_sequencer.sv - multi-chain serial configuration sequencer with command and readback FIFOs
// Define CFG_SEQ_ABORT_EN to add the abort input.
module config_chain_sequencer #(
  parameter int NUM_CHAINS = 4,
  parameter int CMD_DEPTH  = 64,
  parameter int RB_DEPTH   = 16,
  parameter int DIV_W      = 16
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic [DIV_W-1:0]             cfg_half_div,
  input  logic [31:0]                  cmd_data,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level,
  output logic [31:0]                  rb_data,
  output logic                         rb_valid,
  input  logic                         rb_ready,
  output logic                         busy,
  output logic                         err_illegal,
  output logic                         err_overflow,
  input  logic                         clear_errors,
`ifdef CFG_SEQ_ABORT_EN
  input  logic                         abort,
`endif
  output logic [NUM_CHAINS-1:0]        config_clk,
  output logic [NUM_CHAINS-1:0]        config_in,
  output logic [NUM_CHAINS-1:0]        config_load,
  output logic [NUM_CHAINS-1:0]        reset_n,
  input  logic [NUM_CHAINS-1:0]        config_out
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RB_DEPTH);
  localparam logic [CAW:0] CMD_FULL = (CAW+1)'(CMD_DEPTH);
  localparam logic [RAW:0] RB_FULL  = (RAW+1)'(RB_DEPTH);
  localparam logic [3:0] OP_RESET = 4'd1;
  localparam logic [3:0] OP_SHIFT = 4'd2;
  localparam logic [3:0] OP_WAIT  = 4'd3;
  localparam logic [3:0] OP_LOAD  = 4'd4;

  typedef enum logic [2:0] {IDLE, DECODE, RST, SHIFT_LO, SHIFT_HI, LOAD, WAIT, RB_PUSH} state_t;
  state_t state_q, state_d;

  logic abort_i;
`ifdef CFG_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  logic [31:0]      cmd_mem [CMD_DEPTH];
  logic [CAW-1:0]   cmd_wr_ptr, cmd_rd_ptr;
  logic [CAW:0]     cmd_count;
  logic             cmd_push, cmd_pop;
  logic [31:0]      rb_mem [RB_DEPTH];
  logic [RAW-1:0]   rb_wr_ptr, rb_rd_ptr;
  logic [RAW:0]     rb_count;
  logic             rb_push, rb_pop, rb_full;

  logic [31:0]      cmd_word_q;
  logic [DIV_W-1:0] h_m1_q;
  logic [DIV_W:0]   cnt_q;
  logic [3:0]       bit_q;
  logic [15:0]      wait_q;
  logic [15:0]      capture_q;
  logic [NUM_CHAINS-1:0] cfg_out_s1, cfg_out_s2;
  logic             sync_bit;

  logic [3:0]  opcode, chan, nbits_m1;
  logic [15:0] payload;
  logic        illegal, half_end, full_end;

  assign opcode   = cmd_word_q[3:0];
  assign chan     = cmd_word_q[7:4];
  assign nbits_m1 = cmd_word_q[11:8];
  assign payload  = cmd_word_q[31:16];
  assign illegal  = !(opcode inside {OP_RESET, OP_SHIFT, OP_WAIT, OP_LOAD}) ||
                    ({28'd0, chan} >= 32'(NUM_CHAINS));
  assign half_end = (cnt_q == {1'b0, h_m1_q});
  assign full_end = (cnt_q == {h_m1_q, 1'b1});

  assign cmd_ready = (cmd_count != CMD_FULL);
  assign cmd_level = cmd_count;
  assign cmd_push  = cmd_valid && cmd_ready && !abort_i;
  assign cmd_pop   = (state_q == IDLE) && (cmd_count != '0) && !abort_i;
  assign busy      = (state_q != IDLE) || (cmd_count != '0);

  always_ff @(posedge S_AXI_ACLK) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= cmd_data;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else if (abort_i) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rb_full  = (rb_count == RB_FULL);
  assign rb_valid = (rb_count != '0);
  assign rb_data  = rb_mem[rb_rd_ptr];
  assign rb_push  = (state_q == RB_PUSH) && !rb_full && !abort_i;
  assign rb_pop   = rb_valid && rb_ready;

  always_ff @(posedge S_AXI_ACLK) begin
    if (rb_push) rb_mem[rb_wr_ptr] <= {8'h00, nbits_m1, chan, capture_q};
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rb_wr_ptr <= '0;
      rb_rd_ptr <= '0;
      rb_count  <= '0;
    end else begin
      if (rb_push) rb_wr_ptr <= rb_wr_ptr + 1'b1;
      if (rb_pop)  rb_rd_ptr <= rb_rd_ptr + 1'b1;
      case ({rb_push, rb_pop})
        2'b10:   rb_count <= rb_count + 1'b1;
        2'b01:   rb_count <= rb_count - 1'b1;
        default: ;
      endcase
    end
  end

  // A same-cycle error event wins over clear_errors.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if ((state_q == DECODE) && illegal && !abort_i) err_illegal <= 1'b1;
      else if (clear_errors)                          err_illegal <= 1'b0;
      if ((state_q == RB_PUSH) && rb_full && !abort_i) err_overflow <= 1'b1;
      else if (clear_errors)                           err_overflow <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      cfg_out_s1 <= '0;
      cfg_out_s2 <= '0;
    end else begin
      cfg_out_s1 <= config_out;
      cfg_out_s2 <= cfg_out_s1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_count != '0) state_d = DECODE;
      DECODE: begin
        if (illegal) state_d = IDLE;
        else begin
          case (opcode)
            OP_RESET: state_d = RST;
            OP_SHIFT: state_d = SHIFT_LO;
            OP_WAIT:  state_d = (payload == 16'd0) ? IDLE : WAIT;
            default:  state_d = LOAD;
          endcase
        end
      end
      RST, LOAD: if (full_end) state_d = IDLE;
      WAIT:      if (full_end && (wait_q == 16'd1)) state_d = IDLE;
      SHIFT_LO:  if (half_end) state_d = SHIFT_HI;
      SHIFT_HI:  if (half_end) state_d = (bit_q == nbits_m1) ? RB_PUSH : SHIFT_LO;
      RB_PUSH:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      cmd_word_q <= '0;
      h_m1_q     <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      wait_q     <= '0;
      capture_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_pop) cmd_word_q <= cmd_mem[cmd_rd_ptr];
      case (state_q)
        DECODE: begin
          h_m1_q    <= (cfg_half_div == '0) ? '0 : cfg_half_div - 1'b1;
          cnt_q     <= '0;
          bit_q     <= '0;
          wait_q    <= payload;
          capture_q <= '0;
        end
        RST, LOAD: cnt_q <= cnt_q + 1'b1;
        WAIT: begin
          if (full_end) begin
            cnt_q  <= '0;
            wait_q <= wait_q - 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SHIFT_LO: cnt_q <= half_end ? '0 : cnt_q + 1'b1;
        SHIFT_HI: begin
          if (half_end) begin
            cnt_q            <= '0;
            capture_q[bit_q] <= sync_bit;
            bit_q            <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Only the selected chain ever leaves its idle levels.
  always_comb begin
    config_clk  = '0;
    config_in   = '0;
    config_load = '0;
    reset_n     = '1;
    sync_bit    = 1'b0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (chan == 4'(i)) begin
        sync_bit = cfg_out_s2[i];
        case (state_q)
          RST:      reset_n[i]     = 1'b0;
          LOAD:     config_load[i] = 1'b1;
          SHIFT_LO: config_in[i]   = payload[bit_q];
          SHIFT_HI: begin
            config_clk[i] = 1'b1;
            config_in[i]  = payload[bit_q];
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_config_chain_sequencer.sv
// tb/tb_config_chain_sequencer.sv - directed-vector bench for config_chain_sequencer
module tb_config_chain_sequencer;
  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN = 1'b0;
  logic [15:0] cfg_half_div = 16'd1;
  logic [31:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_level;
  logic [31:0] rb_data;
  logic        rb_valid;
  logic        rb_ready = 1'b0;
  logic        busy, err_illegal, err_overflow;
  logic        clear_errors = 1'b0;
`ifdef CFG_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [3:0]  config_clk, config_in, config_load, reset_n, config_out;

  int n_vec = 0;
  int n_err = 0;

  config_chain_sequencer dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN), .cfg_half_div(cfg_half_div),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_level(cmd_level),
    .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready), .busy(busy),
    .err_illegal(err_illegal), .err_overflow(err_overflow), .clear_errors(clear_errors),
`ifdef CFG_SEQ_ABORT_EN
    .abort(abort),
`endif
    .config_clk(config_clk), .config_in(config_in), .config_load(config_load),
    .reset_n(reset_n), .config_out(config_out)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  // Chain 1 is a loopback wire; the other chains return zeros.
  assign config_out = config_in & 4'b0010;

  int cyc = 0, hi1 = 0, rise1 = 0, gap1 = 0, last_rise = 0;
  int other_act = 0, any_act = 0, rst0_lo = 0, load0_hi = 0, load0_clk = 0;
  logic [31:0] word1 = '0;
  logic        prev_clk1 = 1'b0;

  always @(negedge S_AXI_ACLK) begin
    cyc = cyc + 1;
    if (config_clk[1]) hi1 = hi1 + 1;
    if (config_clk[1] && !prev_clk1) begin
      rise1 = rise1 + 1;
      gap1 = cyc - last_rise;
      last_rise = cyc;
      word1 = {config_in[1], word1[31:1]};
    end
    prev_clk1 = config_clk[1];
    if (((config_clk | config_in | config_load | ~reset_n) & 4'b1101) != 4'b0) other_act = other_act + 1;
    if ((config_clk | config_in | config_load | ~reset_n) != 4'b0) any_act = any_act + 1;
    if (!reset_n[0]) rst0_lo = rst0_lo + 1;
    if (config_load[0]) load0_hi = load0_hi + 1;
    if (config_load[0] && config_clk[0]) load0_clk = load0_clk + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge S_AXI_ACLK);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    cmd_data = w;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) step();
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_clk"}, 32'(config_clk), 32'h0);
    chk({tag, "_in"}, 32'(config_in), 32'h0);
    chk({tag, "_load"}, 32'(config_load), 32'h0);
    chk({tag, "_rstn"}, 32'(reset_n), 32'hF);
    chk({tag, "_level"}, 32'(cmd_level), 32'd0);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rbv"}, 32'(rb_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_eill"}, 32'(err_illegal), 32'd0);
    chk({tag, "_eovf"}, 32'(err_overflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h0, r0, o0, a0, rl0, ld0, lc0, drops;
    repeat (3) step();
    chk_idle_outputs("reset");
    S_AXI_ARESETN = 1'b1;
    step();

    // SHIFT ch1, 8 bits of 0xA5, H=2, looped back
    cfg_half_div = 16'd2;
    h0 = hi1; r0 = rise1; o0 = other_act;
    push(32'h00A5_0712);
    wait_idle(200);
    chk("shift_hi_cycles", 32'(hi1 - h0), 32'd16);
    chk("shift_rises", 32'(rise1 - r0), 32'd8);
    chk("shift_period", 32'(gap1), 32'd4);
    chk("shift_serial", {24'd0, word1[31:24]}, 32'h0000_00A5);
    chk("shift_others_idle", 32'(other_act - o0), 32'd0);
    chk("shift_rb_valid", 32'(rb_valid), 32'd1);
    chk("shift_rb_word", rb_data, 32'h0071_00A5);
    rb_ready = 1'b1;
    step();
    rb_ready = 1'b0;
    chk("shift_rb_popped", 32'(rb_valid), 32'd0);

    // RESET then LOAD on ch0, H=3
    cfg_half_div = 16'd3;
    rl0 = rst0_lo; ld0 = load0_hi; lc0 = load0_clk;
    push(32'h0000_0001);
    push(32'h0000_0004);
    wait_idle(200);
    chk("reset_low_cycles", 32'(rst0_lo - rl0), 32'd6);
    chk("load_high_cycles", 32'(load0_hi - ld0), 32'd6);
    chk("load_clk_low", 32'(load0_clk - lc0), 32'd0);

    // illegal opcode, then out-of-range channel
    a0 = any_act;
    push(32'h0000_0007);
    push(32'h0000_0042);
    wait_idle(50);
    chk("illegal_no_toggle", 32'(any_act - a0), 32'd0);
    chk("illegal_flag", 32'(err_illegal), 32'd1);
    chk("illegal_no_ovf", 32'(err_overflow), 32'd0);
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    chk("illegal_cleared", 32'(err_illegal), 32'd0);

    // 17 SHIFTs into a 16-deep readback FIFO
    cfg_half_div = 16'd2;
    for (int i = 0; i < 17; i++) push((32'(i) << 16) | 32'h0000_0312);
    wait_idle(2000);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_rb_valid", 32'(rb_valid), 32'd1);
    rb_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_word%0d", i), rb_data, 32'h0031_0000 | 32'(i));
      step();
    end
    rb_ready = 1'b0;
    chk("ovf_drained", 32'(rb_valid), 32'd0);
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    chk("ovf_cleared", 32'(err_overflow), 32'd0);

    // fill the command FIFO behind a long WAIT
    cfg_half_div = 16'd1;
    push(32'h00C8_0003);
    step();
    step();
    cmd_data = 32'h0001_0003;
    cmd_valid = 1'b1;
    for (int k = 0; k < 64; k++) step();
    cmd_valid = 1'b0;
    chk("fill_level", 32'(cmd_level), 32'd64);
    chk("fill_not_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("fill_refused", 32'(cmd_level), 32'd64);
    drops = 0;
    for (int i = 0; i < 1500 && cmd_level != 7'd0; i++) begin
      if (!busy) drops++;
      step();
    end
    chk("fill_emptied", 32'(cmd_level), 32'd0);
    chk("fill_busy_steady", 32'(drops), 32'd0);
    chk("fill_busy_tail", 32'(busy), 32'd1);
    wait_idle(50);

    // asynchronous reset in the middle of a SHIFT
    cfg_half_div = 16'd4;
    push(32'hFFFF_0F12);
    push(32'h0001_0003);
    repeat (10) step();
    chk("pre_rst_clk_active", 32'(config_in[1]), 32'd1);
    chk("pre_rst_level", 32'(cmd_level), 32'd1);
    #2;
    S_AXI_ARESETN = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    step();
    S_AXI_ARESETN = 1'b1;
    step();
    chk_idle_outputs("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
